muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit owning the MIPS HI/LO register pair. It sits beside the combinational `alu` in the execute stage. It accepts MULT/MULTU/DIV/DIVU on a start strobe, computes over multiple cycles with a busy/done handshake, and holds results in HI/LO for MFHI/MFLO. It also accepts direct MTHI/MTLO writes.

## Interface
- `DATA_WIDTH`, 32, operand and HI/LO width.
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst_n`  input  1  synchronous, active-low reset.
- `i_start`  input  1  start strobe; sampled only in IDLE.
- `i_op`  input  2  operation code: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `i_data_a`  input  DATA_WIDTH  multiplicand or dividend.
- `i_data_b`  input  DATA_WIDTH  multiplier or divisor.
- `i_mthi`  input  1  write `i_din` to HI.
- `i_mtlo`  input  1  write `i_din` to LO.
- `i_din`  input  DATA_WIDTH  data for MTHI/MTLO.
- `o_hi`  output  DATA_WIDTH  HI register.
- `o_lo`  output  DATA_WIDTH  LO register.
- `o_busy`  output  1  operation in progress; the pipeline stalls HI/LO consumers while it is high.
- `o_done`  output  1  one-cycle pulse when HI/LO take a new result.

## Operation
- Clock `i_clk`; reset `i_rst_n` is synchronous and active-low.
- States:
  - IDLE: waits for `i_start`.
  - CALC: runs DATA_WIDTH iterations.
  - FIX: applies the sign correction and writes HI/LO.
- Transitions: IDLE→CALC on `i_start`; CALC→FIX when the iteration counter reaches DATA_WIDTH−1; FIX→IDLE unconditionally.
- On start, `i_op`, `i_data_a` and `i_data_b` are latched. Later input changes have no effect.
- Signed ops (MULT, DIV) latch the operand magnitudes plus the sign bits. Unsigned ops latch the raw operands.
- Multiply: shift-add, one multiplier bit per cycle, into a 2×DATA_WIDTH accumulator.
  - FIX negates the 64-bit product if the operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per cycle.
  - FIX: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero (`i_data_b`==0): the iterations still run, but FIX writes LO = all ones and HI = original `i_data_a`, with no sign fix.
- Signed overflow (−2^31 / −1): LO = 0x80000000, HI = 0. No flag is raised.
- MTHI/MTLO:
  - Honoured only in IDLE and only when `i_start` is low.
  - Both strobes may be asserted together; both registers are then written.
  - They are ignored while busy.
- `i_start` while busy is ignored; the request is not queued.

## Timing
- Reset values: `o_hi`=0, `o_lo`=0, `o_busy`=0, `o_done`=0, state IDLE, counter 0.
- Reset mid-operation aborts the operation and restores the reset values; the partial result is discarded.
- With the start accepted at edge E0:
  - `o_busy` is 1 after E0 through the cycle before E(DATA_WIDTH+1).
  - FIX runs at edge E(DATA_WIDTH+1), i.e. E33 for 32 bits.
  - After E33, `o_hi`/`o_lo` hold the result, `o_done`=1 for exactly one cycle, and `o_busy`=0.
- Latency: DATA_WIDTH+1 cycles from start to done.
- Back-to-back operation: a new `i_start` may be accepted in the cycle in which `o_done`=1, since the state is IDLE. Its `o_done` pulse comes 33 cycles later.
- MTHI/MTLO latency: one edge; `o_done` is not asserted.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Full unit as described above.
- `MULDIV_DIV_EN` undefined:
  - Divide datapath is omitted.
  - A DIV/DIVU start is ignored: the state stays IDLE, `o_busy` stays 0, no `o_done`, and HI/LO are unchanged.
  - Multiply timing is identical.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=7 → 33 cycles later `o_done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `o_busy` high for exactly 33 cycles.
- MULTU, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; second start asserted mid-operation is ignored.
- DIV, a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, a=100, b=7 → LO=0x0000000E, HI=0x00000002 (with `MULDIV_DIV_EN` undefined: no busy, HI/LO unchanged).
- DIV by zero, a=5, b=0 → LO=0xFFFFFFFF, HI=0x00000005. DIV, a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI+MTLO in IDLE with `i_din`=0x12345678 → both regs equal 0x12345678 next cycle. MTLO asserted while busy → ignored. MTHI with simultaneous `i_start` → start wins, HI gets the result.
- `i_rst_n` low at cycle 10 of a MULT → next edge: HI=LO=0, `o_busy`=0, no `o_done`. A fresh MULT 6×7 afterwards gives LO=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Divide datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_mthi,
  input  logic                  i_mtlo,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic            neg_res;

  logic            sa;
  logic            sb;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            start_ok;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  step_next;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;

  assign sa    = ~i_op[0] & i_data_a[W-1];
  assign sb    = ~i_op[0] & i_data_b[W-1];
  assign mag_a = sa ? -i_data_a : i_data_a;
  assign mag_b = sb ? -i_data_b : i_data_b;

  // acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*W-1:W]}
                  + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};
  assign prod     = neg_res ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic            is_div;
  logic            neg_rem;
  logic            div_zero;
  logic [W:0]      div_sh;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  div_next;

  assign start_ok = i_start;

  // acc = {partial remainder, dividend/quotient bits}
  assign div_sh   = {acc[2*W-1:W], acc[W-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_next = div_diff[W]
                  ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                  : {div_diff[W-1:0], acc[W-2:0], 1'b1};
`else
  assign start_ok = i_start & ~i_op[1];
`endif

  always_comb begin
    step_next = mul_next;
    fix_hi    = prod[2*W-1:W];
    fix_lo    = prod[W-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      step_next = div_next;
      // With a zero divisor the remainder is |a|, so the
      // remainder sign fix restores the original dividend.
      fix_hi = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (div_zero)
        fix_lo = '1;
      else
        fix_lo = neg_res ? -acc[W-1:0] : acc[W-1:0];
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      o_hi     <= '0;
      o_lo     <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= CALC;
            o_busy  <= 1'b1;
            cnt     <= '0;
            neg_res <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            is_div   <= i_op[1];
            neg_rem  <= sa;
            div_zero <= (i_data_b == '0);
            if (i_op[1]) begin
              opnd <= mag_b;
              acc  <= {{W{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{W{1'b0}}, mag_b};
            end
`else
            opnd <= mag_a;
            acc  <= {{W{1'b0}}, mag_b};
`endif
          end else if (!i_start) begin
            if (i_mthi) o_hi <= i_din;
            if (i_mtlo) o_lo <= i_din;
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          o_hi   <= fix_hi;
          o_lo   <= fix_lo;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Divide vectors depend on MULDIV_DIV_EN.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] din;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_data_a (a),
    .i_data_b (b),
    .i_mthi   (mthi),
    .i_mtlo   (mtlo),
    .i_din    (din),
    .o_hi     (hi),
    .o_lo     (lo),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start, then scrambles the operands.
  task automatic go(input logic [1:0] o,
                    input logic [W-1:0] x,
                    input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = 32'hDEADBEEF;
    b     = 32'h0BADF00D;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 60) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (hi !== 32'h0) begin
      errors++;
      $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0);
    end
    checks++;
    if (lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int lat;
    int nb;
    go(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, nb);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL mult_latency got=%0d exp=33", lat);
    end
    checks++;
    if (nb !== 33) begin
      errors++;
      $display("FAIL mult_busy_cycles got=%0d exp=33", nb);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_busy_at_done got=%b exp=0", busy);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFFFFFF);
    end
    checks++;
    if (lo !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFFFFEB);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_multu();
    int lat;
    int nb;
    go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) tick();
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd2;
    b     = 32'd2;
    tick();
    start = 1'b0;
    wait_done(lat, nb);
    checks++;
    if (lat !== 22) begin
      errors++;
      $display("FAIL multu_latency got=%0d exp=22", lat);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_hi got=%h exp=%h", hi, 32'hFFFFFFFE);
    end
    checks++;
    if (lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_lo got=%h exp=%h", lo, 32'h1);
    end
    tick();
    repeat (35) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL multu_queued busy=%b done=%b exp=0/0",
                 busy, done);
      end
      tick();
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int lat;
    int nb;
    go(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, nb);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL div_latency got=%0d exp=33", lat);
    end
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_signed got=%h/%h exp=%h/%h",
               hi, lo, 32'hFFFFFFFF, 32'hFFFFFFFD);
    end
    tick();
    go(2'b11, 32'd100, 32'd7);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'h0000000E || hi !== 32'h00000002) begin
      errors++;
      $display("FAIL divu got=%h/%h exp=%h/%h",
               hi, lo, 32'h2, 32'hE);
    end
    tick();
    go(2'b10, 32'd5, 32'd0);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h00000005) begin
      errors++;
      $display("FAIL div_zero got=%h/%h exp=%h/%h",
               hi, lo, 32'h5, 32'hFFFFFFFF);
    end
    tick();
    go(2'b10, 32'hFFFFFFFB, 32'd0);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL div_zero_neg got=%h/%h exp=%h/%h",
               hi, lo, 32'hFFFFFFFB, 32'hFFFFFFFF);
    end
    tick();
    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++;
      $display("FAIL div_ovf got=%h/%h exp=%h/%h",
               hi, lo, 32'h0, 32'h80000000);
    end
    tick();
  endtask
`else
  task automatic test_div();
    logic [W-1:0] hi0;
    logic [W-1:0] lo0;
    int seen;
    hi0  = hi;
    lo0  = lo;
    seen = 0;
    go(2'b11, 32'd100, 32'd7);
    repeat (40) begin
      if (busy || done) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL div_disabled_activity got=%0d exp=0", seen);
    end
    checks++;
    if (hi !== hi0 || lo !== lo0) begin
      errors++;
      $display("FAIL div_disabled_hilo got=%h/%h exp=%h/%h",
               hi, lo, hi0, lo0);
    end
  endtask
`endif

  task automatic test_mt();
    int lat;
    int nb;
    mthi = 1'b1;
    mtlo = 1'b1;
    din  = 32'h12345678;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'h12345678) begin
      errors++;
      $display("FAIL mt_both got=%h/%h exp=%h/%h",
               hi, lo, 32'h12345678, 32'h12345678);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_flags done=%b busy=%b exp=0/0",
               done, busy);
    end
    go(2'b00, 32'd6, 32'd7);
    repeat (5) tick();
    mtlo = 1'b1;
    din  = 32'h0000DEAD;
    tick();
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h12345678) begin
      errors++;
      $display("FAIL mtlo_busy got=%h exp=%h", lo, 32'h12345678);
    end
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'd42 || hi !== 32'h0) begin
      errors++;
      $display("FAIL mt_mult got=%h/%h exp=%h/%h",
               hi, lo, 32'h0, 32'd42);
    end
    tick();
    mthi = 1'b1;
    din  = 32'h00000055;
    tick();
    mthi = 1'b0;
    mthi = 1'b1;
    din  = 32'h0000AAAA;
    go(2'b00, 32'd2, 32'd3);
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h00000055) begin
      errors++;
      $display("FAIL mthi_start_edge got=%h exp=%h",
               hi, 32'h55);
    end
    wait_done(lat, nb);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL mthi_start got=%h/%h exp=%h/%h",
               hi, lo, 32'h0, 32'd6);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int nb;
    int seen;
    go(2'b00, 32'd5, 32'd5);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_hilo got=%h/%h exp=0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags busy=%b done=%b exp=0/0",
               busy, done);
    end
    seen = 0;
    repeat (40) begin
      if (busy || done) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done got=%0d exp=0", seen);
    end
    go(2'b00, 32'd6, 32'd7);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'd42 || hi !== 32'h0 || lat !== 33) begin
      errors++;
      $display("FAIL rstmid_fresh got=%h/%h lat=%0d exp=0/2a lat=33",
               hi, lo, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int nb;
    go(2'b01, 32'd3, 32'd4);
    wait_done(lat, nb);
    checks++;
    if (lo !== 32'd12) begin
      errors++;
      $display("FAIL b2b_first got=%h exp=%h", lo, 32'd12);
    end
    go(2'b01, 32'd25, 32'd25);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got=%b exp=1", busy);
    end
    wait_done(lat, nb);
    checks++;
    if (lat !== 33 || lo !== 32'd625 || hi !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second got=%h/%h lat=%0d exp=0/271 lat=33",
               hi, lo, lat);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    din   = '0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
